bnn_xnor_neuron: RTL and testbench

Serial binarized-neuron datapath for the BNN tile: accepts one byte of binary activations and one byte of binary weights per handshake, accumulates the XNOR popcount over a fixed fan-in, and emits the thresholded output activation plus the raw popcount. Sits directly downstream of the input byte loader driven from `ui_in` and upstream of the output logic that drives `uo_out` in `tt_um_counter`.

---
 rtl/bnn_xnor_neuron.sv | 158 +++++++++++++++
 tb/tb_bnn_xnor_neuron.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_xnor_neuron.sv
// -----------------------------------------------------------------------------
// bnn_xnor_neuron
//
// Serial binarized neuron. Each accepted input beat carries one byte of binary
// activations and one byte of binary weights (1 = +1, 0 = -1). The XNOR of the
// two bytes marks the positions where activation and weight agree; the
// popcount of that XNOR is accumulated over NBYTES beats. After the last beat
// the total popcount and its thresholded bit are registered and presented on
// a valid/ready output port until the consumer takes them.
//
// Parameters:
//   NBYTES      input bytes per evaluation (fan-in = 8*NBYTES), 1..31
//   CW          popcount / threshold width, wide enough to hold 8*NBYTES
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    act/wgt byte pair valid
//   in_ready    block accepts a byte pair (registered state only)
//   act         binary activations
//   wgt         binary weights
//   thresh      threshold, sampled only on the final input beat
//   out_valid   result valid (registered state only)
//   out_ready   consumer accepts the result
//   out_bit     1 when popcount >= thresh
//   out_popcnt  total XNOR popcount of the evaluation
// -----------------------------------------------------------------------------
module bnn_xnor_neuron #(
    parameter int NBYTES = 4,
    parameter int CW     = $clog2(8 * NBYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    act,
    input  logic [7:0]    wgt,
    input  logic [CW-1:0] thresh,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic [CW-1:0] out_popcnt
);

    // Beat counter needs at least one bit even when NBYTES == 1.
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBYTES - 1);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic            out_bit_q;
    logic [CW-1:0]   out_popcnt_q;

    logic            in_fire;
    logic            out_fire;
    logic            last_beat;
    logic [CW-1:0]   beat_pop;
    logic [CW-1:0]   beat_sum;

    // Number of agreeing positions between the activation and weight bytes.
    function automatic logic [CW-1:0] xnor_popcount(input logic [7:0] a,
                                                    input logic [7:0] w);
        logic [7:0]    agree;
        logic [CW-1:0] n;
        agree = ~(a ^ w);
        n     = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + CW'(agree[i]);
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake and datapath combinational terms
    // -------------------------------------------------------------------------
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_beat = (cnt_q == LAST_BEAT);
    assign beat_pop  = xnor_popcount(act, wgt);
    // Cannot wrap: the largest possible total, 8*NBYTES, fits in CW bits.
    assign beat_sum  = acc_q + beat_pop;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its inputs, independent of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: defaulting state_d before the case keeps every path assigned, so
    // no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: if (in_fire && last_beat) state_d = ST_OUT;
            ST_OUT: if (out_fire)             state_d = ST_ACC;
            default:                          state_d = ST_ACC;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs, decoded from the registered state only so neither ready
    // nor valid has a combinational path from the opposite handshake.
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACC:  in_ready  = 1'b1;
            ST_OUT:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Accumulator, beat counter and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_bit_q    <= 1'b0;
            out_popcnt_q <= '0;
        end else if (in_fire) begin
            if (last_beat) begin
                // Final beat: capture the total and compare against the
                // threshold presented on this same cycle; restart the sum.
                out_popcnt_q <= beat_sum;
                out_bit_q    <= (beat_sum >= thresh);
                acc_q        <= '0;
                cnt_q        <= '0;
            end else begin
                acc_q <= beat_sum;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_bit    = out_bit_q;
    assign out_popcnt = out_popcnt_q;

endmodule

// File: tb/tb_bnn_xnor_neuron.sv
// -----------------------------------------------------------------------------
// tb_bnn_xnor_neuron
//
// Directed bench for bnn_xnor_neuron (NBYTES = 4). A behavioural model tracks
// the evaluation as a running list of accepted beats and a pending-result
// flag; a compare process checks the DUT against it on every falling edge.
// Directed sequences additionally pin hand-computed results.
// -----------------------------------------------------------------------------
module tb_bnn_xnor_neuron;

    localparam int NBYTES = 4;
    localparam int CW     = $clog2(8 * NBYTES + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    act;
    logic [7:0]    wgt;
    logic [CW-1:0] thresh;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic [CW-1:0] out_popcnt;

    int n_vec  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    bnn_xnor_neuron #(.NBYTES(NBYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .act        (act),
        .wgt        (wgt),
        .thresh     (thresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_popcnt (out_popcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: beats accepted so far in this evaluation, their
    // summed agreement count, and the pending result awaiting an output beat.
    // -------------------------------------------------------------------------
    int m_beats   = 0;
    int m_sum     = 0;
    bit m_pending = 1'b0;
    int m_pop     = 0;
    bit m_bit     = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_beats   <= 0;
            m_sum     <= 0;
            m_pending <= 1'b0;
        end else if (m_pending) begin
            if (out_ready) m_pending <= 1'b0;
        end else if (in_valid) begin
            if (m_beats == NBYTES - 1) begin
                m_pop     <= m_sum + $countones(~(act ^ wgt));
                m_bit     <= (m_sum + $countones(~(act ^ wgt))) >= int'(thresh);
                m_pending <= 1'b1;
                m_beats   <= 0;
                m_sum     <= 0;
            end else begin
                m_beats <= m_beats + 1;
                m_sum   <= m_sum + $countones(~(act ^ wgt));
            end
        end
    end

    // Compare process: handshake every cycle, result whenever one is pending.
    always @(negedge clk) begin
        if (started && !rst) begin
            check("model_in_ready", 32'(in_ready), 32'(!m_pending));
            check("model_out_valid", 32'(out_valid), 32'(m_pending));
            if (m_pending) begin
                check("model_out_popcnt", 32'(out_popcnt), 32'(m_pop));
                check("model_out_bit", 32'(out_bit), 32'(m_bit));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers; inputs change 1 time unit after the rising edge.
    // -------------------------------------------------------------------------
    task automatic idle_inputs();
        in_valid = 1'b0;
        act      = 8'($urandom);
        wgt      = 8'($urandom);
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] w,
                        input logic [CW-1:0] t);
        in_valid = 1'b1;
        act      = a;
        wgt      = w;
        thresh   = t;
        @(posedge clk);
        #1;
        idle_inputs();
        thresh = CW'($urandom);
    endtask

    // Waits (bounded) for out_valid; returns at a falling edge.
    task automatic wait_out(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        check("wait_out_timeout", 32'(found), 32'd1);
    endtask

    // One full evaluation: same byte pair on every beat, t_other on the
    // non-final beats and t_last on the final one; result consumed at once.
    task automatic run_eval(input string name, input logic [7:0] a,
                            input logic [7:0] w, input logic [CW-1:0] t_last,
                            input logic [CW-1:0] t_other, input int exp_pop,
                            input bit exp_bit);
        bit found;
        for (int i = 0; i < NBYTES; i++) begin
            beat(a, w, (i == NBYTES - 1) ? t_last : t_other);
        end
        wait_out(found);
        if (found) begin
            check({name, "_popcnt"}, 32'(out_popcnt), 32'(exp_pop));
            check({name, "_bit"}, 32'(out_bit), 32'(exp_bit));
        end
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequences
    // -------------------------------------------------------------------------
    initial begin
        bit                found;
        logic [CW-1:0]     held_pop;
        logic              held_bit;
        logic [6:0]        gap_pattern;

        rst       = 1'b1;
        out_ready = 1'b1;
        thresh    = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_bit", 32'(out_bit), 32'd0);
        check("reset_out_popcnt", 32'(out_popcnt), 32'd0);
        started = 1'b1;
        @(posedge clk);
        #1;

        // All agree: 32 of 32, one cycle latency, ACC again after output beat.
        for (int i = 0; i < NBYTES; i++) beat(8'hFF, 8'hFF, CW'(16));
        @(negedge clk);
        check("first_latency_valid", 32'(out_valid), 32'd1);
        check("first_popcnt", 32'(out_popcnt), 32'd32);
        check("first_bit", 32'(out_bit), 32'd1);
        check("first_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("first_back_to_acc", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Boundary thresholds.
        run_eval("none_agree_t0", 8'hFF, 8'h00, CW'(0), CW'(0), 0, 1'b1);
        run_eval("none_agree_t1", 8'hFF, 8'h00, CW'(1), CW'(1), 0, 1'b0);
        run_eval("half_t16", 8'h0F, 8'hFF, CW'(16), CW'(16), 16, 1'b1);
        run_eval("half_t17", 8'h0F, 8'hFF, CW'(17), CW'(17), 16, 1'b0);
        run_eval("thresh_above_max", 8'hFF, 8'hFF, CW'(33), CW'(33), 32, 1'b0);
        // Threshold on non-final beats must be ignored.
        run_eval("early_thresh_low", 8'h0F, 8'hFF, CW'(17), CW'(0), 16, 1'b0);
        run_eval("early_thresh_high", 8'h0F, 8'hFF, CW'(16), CW'(63), 16, 1'b1);
        // Mixed bytes: ~(0x3C ^ 0x5A) = ~0x66 = 0x99 -> 4 agree per byte.
        run_eval("mixed_3c_5a", 8'h3C, 8'h5A, CW'(10), CW'(10), 16, 1'b1);

        // Gaps in in_valid: pattern 1,0,0,1,0,1,1 with 0xA5/0xA5.
        gap_pattern = 7'b1101001; // bit 0 is applied first
        for (int i = 0; i < 7; i++) begin
            if (gap_pattern[i]) begin
                in_valid = 1'b1;
                act      = 8'hA5;
                wgt      = 8'hA5;
                thresh   = CW'(20);
            end else begin
                idle_inputs();
            end
            @(posedge clk);
            #1;
            if (i == 5) begin
                @(negedge clk);
                check("gap_no_early_valid", 32'(out_valid), 32'd0);
            end
        end
        idle_inputs();
        @(negedge clk);
        check("gap_valid", 32'(out_valid), 32'd1);
        check("gap_popcnt", 32'(out_popcnt), 32'd32);
        check("gap_bit", 32'(out_bit), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: hold the result for 5 cycles.
        out_ready = 1'b0;
        for (int i = 0; i < NBYTES; i++) beat(8'hF0, 8'hFF, CW'(16));
        wait_out(found);
        held_pop = out_popcnt;
        held_bit = out_bit;
        check("bp_popcnt", 32'(held_pop), 32'd16);
        check("bp_bit", 32'(held_bit), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; // must be refused while the result is pending
            @(negedge clk);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_popcnt_stable", 32'(out_popcnt), 32'(held_pop));
            check("bp_bit_stable", 32'(out_bit), 32'(held_bit));
        end
        idle_inputs();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-evaluation discards the partial sum.
        beat(8'hFF, 8'hFF, CW'(16));
        beat(8'hFF, 8'hFF, CW'(16));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_eval("after_mid_reset", 8'hFF, 8'hFF, CW'(16), CW'(16), 32, 1'b1);

        // Reset during OUT drops the pending result.
        out_ready = 1'b0;
        for (int i = 0; i < NBYTES; i++) beat(8'hFF, 8'hFF, CW'(16));
        wait_out(found);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("out_reset_valid", 32'(out_valid), 32'd0);
        check("out_reset_ready", 32'(in_ready), 32'd1);
        check("out_reset_popcnt", 32'(out_popcnt), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Evaluation after that reset still works.
        run_eval("post_out_reset", 8'h00, 8'h00, CW'(32), CW'(5), 32, 1'b1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
